// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decrypt path.
// Message RAM writer state encoding and ASCII bounds.
package rc4_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_INC,
    S_DONE
  } wr_state_t;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int MSG_LEN = 32;
  localparam int IDX_W   = 9;
  localparam int ADDR_W  = 8;

endpackage

// File: rtl/write_ram_mem_if.sv
// Datapath/master-FSM side of the message RAM writer.
// Carries start/done, the byte handshake and the RAM write port.
interface write_ram_mem_if #(
  parameter int WID = 8
) ();

  logic           start;
  logic [WID-1:0] data_in;
  logic           data_valid;
  logic           ready;
  logic [7:0]     address;
  logic [WID-1:0] ram_data;
  logic           wren;
  logic           done;
  logic           invalid;

  modport master (
    output start,
    output data_in,
    output data_valid,
    input  ready,
    input  address,
    input  ram_data,
    input  wren,
    input  done,
    input  invalid
  );

  modport slave (
    input  start,
    input  data_in,
    input  data_valid,
    output ready,
    output address,
    output ram_data,
    output wren,
    output done,
    output invalid
  );

endinterface

// File: rtl/ascii_char_check.sv
// Flags bytes that can appear in a plaintext message.
// Lowercase letters and space only.
module ascii_char_check
  import rc4_pkg::*;
#(
  parameter int WID = 8
) (
  input  logic [WID-1:0] ch,
  output logic           is_valid
);

  logic is_lower;
  logic is_space;

  assign is_lower = (ch >= WID'(CHAR_LO)) &&
                    (ch <= WID'(CHAR_HI));
  assign is_space = (ch == WID'(CHAR_SPACE));
  assign is_valid = is_lower || is_space;

endmodule

// File: rtl/write_ram_mem.sv
// Sequential writer of decrypted bytes into result RAM.
// Optional early reject: RAM_WRITER_CHAR_CHECK_EN.
module write_ram_mem
  import rc4_pkg::*;
#(
  parameter int DEP = MSG_LEN,
  parameter int WID = 8
) (
  input  logic         clk,
  input  logic         reset,
  write_ram_mem_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEP - 1);

  wr_state_t      state;
  wr_state_t      state_nx;
  logic [IDX_W-1:0] idx;
  logic [WID-1:0] data_q;
  logic           done_q;
  logic           xfer;
  logic           char_ok;

`ifdef RAM_WRITER_CHAR_CHECK_EN
  logic inv_q;

  ascii_char_check #(
    .WID(WID)
  ) u_chk (
    .ch      (bus.data_in),
    .is_valid(char_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:   inv_q <= 1'b0;
        S_ACCEPT: if (xfer && !char_ok) inv_q <= 1'b1;
        S_DONE:   if (!bus.start) inv_q <= 1'b0;
        default:  inv_q <= inv_q;
      endcase
    end
  end

  assign bus.invalid = inv_q;
`else
  assign char_ok     = 1'b1;
  assign bus.invalid = 1'b0;
`endif

  assign xfer         = bus.ready && bus.data_valid;
  assign bus.ready    = (state == S_ACCEPT);
  assign bus.wren     = (state == S_WRITE);
  assign bus.address  = idx[ADDR_W-1:0];
  assign bus.ram_data = data_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (xfer) state_nx = char_ok ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        state_nx = S_INC;
      end
      S_INC: begin
        state_nx = done_q ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        if (!bus.start) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // done drops on the DONE->IDLE edge so it clears the cycle start is seen low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          idx    <= '0;
          done_q <= 1'b0;
        end
        S_ACCEPT: begin
          if (xfer) begin
            if (char_ok) data_q <= bus.data_in;
            else         done_q <= 1'b1;
          end
        end
        S_WRITE: begin
          if (idx == LAST) done_q <= 1'b1;
        end
        S_INC: begin
          if (!done_q) idx <= idx + IDX_W'(1);
        end
        S_DONE: begin
          if (!bus.start) done_q <= 1'b0;
        end
        default: begin
          done_q <= done_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_ram_mem.sv
// Scoreboard bench for write_ram_mem (DEP 32, 1, 256).
// Char-check steps run when RAM_WRITER_CHAR_CHECK_EN is defined.
module tb_write_ram_mem;
  import rc4_pkg::*;

`ifdef RAM_WRITER_CHAR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  write_ram_mem_if #(.WID(8)) m ();
  write_ram_mem_if #(.WID(8)) a1 ();
  write_ram_mem_if #(.WID(8)) a2 ();

  write_ram_mem #(.DEP(32), .WID(8)) dut (
    .clk(clk), .reset(rst_n), .bus(m));
  write_ram_mem #(.DEP(1), .WID(8)) u1 (
    .clk(clk), .reset(rst_n), .bus(a1));
  write_ram_mem #(.DEP(256), .WID(8)) u2 (
    .clk(clk), .reset(rst_n), .bus(a2));

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] q[$];
  logic [7:0]  exp_addr;
  logic [7:0]  ram_model [256];
  logic [7:0]  sent [32];
  logic        mon_en = 1'b0;
  logic        aux_en = 1'b0;
  logic        strict = 1'b0;
  logic        acc_prev = 1'b0;
  logic        prev_wr_strict = 1'b0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          cnt1 = 0;
  int          cnt2 = 0;
  logic [7:0]  last2 = 8'h00;

  function automatic logic char_ok(input logic [7:0] b);
    return !CHK || (b >= 8'h61 && b <= 8'h7A) || (b == 8'h20);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic got;
    got = 1'b0;
    if (gap > 0) begin
      m.data_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    m.data_in = b;
    m.data_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m.ready) begin
        got = 1'b1;
        break;
      end
    end
    check("accept", 32'(got), 1);
    if (got && char_ok(b)) begin
      q.push_back({exp_addr, b});
      exp_addr = exp_addr + 8'd1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      acc_prev <= 1'b0;
    end else begin
      if (mon_en) begin
        check("wren_timing", 32'(m.wren), 32'(acc_prev));
        if (m.wren) begin
          check("sb_nonempty", 32'(q.size() > 0), 1);
          if (q.size() > 0) begin
            logic [15:0] e;
            e = q.pop_front();
            check("addr", 32'(m.address), 32'(e[15:8]));
            check("data", 32'(m.ram_data), 32'(e[7:0]));
          end
          ram_model[m.address] <= m.ram_data;
          if (strict && prev_wr_strict)
            check("spacing", 32'(cyc - last_wr_cyc), 3);
          last_wr_cyc <= cyc;
          prev_wr_strict <= strict;
        end
      end
      acc_prev <= m.ready && m.data_valid && char_ok(m.data_in);
    end
  end

  always @(negedge clk) begin
    if (rst_n && aux_en) begin
      if (a1.wren) begin
        check("a1_addr", 32'(a1.address), 32'(cnt1[7:0]));
        cnt1 <= cnt1 + 1;
      end
      if (a2.wren) begin
        check("a2_addr", 32'(a2.address), 32'(cnt2[7:0]));
        cnt2 <= cnt2 + 1;
        last2 <= a2.address;
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic got2;
    m.start = 1'b0;
    m.data_in = 8'h00;
    m.data_valid = 1'b0;
    a1.start = 1'b0;
    a1.data_in = 8'h00;
    a1.data_valid = 1'b0;
    a2.start = 1'b0;
    a2.data_in = 8'h00;
    a2.data_valid = 1'b0;
    exp_addr = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(m.ready), 0);
    check("rst_wren", 32'(m.wren), 0);
    check("rst_done", 32'(m.done), 0);
    check("rst_invalid", 32'(m.invalid), 0);
    check("rst_address", 32'(m.address), 0);
    check("rst_ram_data", 32'(m.ram_data), 0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset while a word is being written
    mon_en = 1'b1;
    m.start = 1'b1;
    send(8'h61, 0);
    m.data_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_wren", 32'(m.wren), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_wren", 32'(m.wren), 0);
    check("async_done", 32'(m.done), 0);
    check("async_ready", 32'(m.ready), 0);
    m.start = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(m.ready), 0);

    // normal message, valid held high
    @(posedge clk); #1;
    m.start = 1'b1;
    exp_addr = 8'h00;
    @(negedge clk);
    check("idle_ready", 32'(m.ready), 0);
    @(negedge clk);
    check("start_ready", 32'(m.ready), 1);
    @(posedge clk); #1;
    strict = 1'b1;
    for (int i = 0; i < 32; i++) begin
      b = 8'h61 + 8'(i % 26);
      send(b, 0);
    end
    m.data_valid = 1'b0;
    @(negedge clk);
    check("last_wren", 32'(m.wren), 1);
    check("last_addr", 32'(m.address), 31);
    @(negedge clk);
    check("done_rise", 32'(m.done), 1);
    check("done_wren", 32'(m.wren), 0);
    strict = 1'b0;
    @(negedge clk);
    check("done_hold", 32'(m.done), 1);
    check("done_ready", 32'(m.ready), 0);
    check("msg1_drain", 32'(q.size()), 0);
    check("msg1_invalid", 32'(m.invalid), 0);

    // restart
    @(posedge clk); #1;
    m.start = 1'b0;
    @(negedge clk);
    check("restart_done_hold", 32'(m.done), 1);
    @(negedge clk);
    check("restart_done_clr", 32'(m.done), 0);

    // back-pressure, start dropped mid-message
    @(posedge clk); #1;
    m.start = 1'b1;
    exp_addr = 8'h00;
    for (int i = 0; i < 32; i++) begin
      b = 8'h61 + 8'($urandom_range(0, 25));
      sent[i] = b;
      send(b, int'($urandom_range(0, 3)));
      if (i == 10) m.start = 1'b0;
    end
    m.data_valid = 1'b0;
    @(negedge clk);
    check("bp_last_wren", 32'(m.wren), 1);
    @(negedge clk);
    check("bp_done", 32'(m.done), 1);
    check("bp_drain", 32'(q.size()), 0);
    for (int i = 0; i < 32; i++)
      check("ram", 32'(ram_model[i]), 32'(sent[i]));
    check("bp_invalid", 32'(m.invalid), 0);
    repeat (2) @(negedge clk);
    check("bp_idle_done", 32'(m.done), 0);

`ifdef RAM_WRITER_CHAR_CHECK_EN
    @(posedge clk); #1;
    m.start = 1'b1;
    exp_addr = 8'h00;
    send(8'h61, 0);
    send(8'h20, 0);
    send(8'h41, 0);
    m.data_valid = 1'b0;
    @(negedge clk);
    check("chk_invalid", 32'(m.invalid), 1);
    check("chk_done", 32'(m.done), 1);
    check("chk_wren", 32'(m.wren), 0);
    check("chk_drain", 32'(q.size()), 0);
    check("chk_ram0", 32'(ram_model[0]), 32'h61);
    check("chk_ram1", 32'(ram_model[1]), 32'h20);
    @(posedge clk); #1;
    m.start = 1'b0;
    @(negedge clk);
    check("chk_inv_clr", 32'(m.invalid), 0);
`endif

    // boundary depths 1 and 256
    @(posedge clk); #1;
    aux_en = 1'b1;
    a1.data_in = 8'h5A;
    a2.data_in = 8'h33;
    a1.data_valid = 1'b1;
    a2.data_valid = 1'b1;
    a1.start = 1'b1;
    a2.start = 1'b1;
    got2 = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (a2.done) begin
        got2 = 1'b1;
        break;
      end
    end
    check("a2_done_seen", 32'(got2), 1);
    repeat (3) @(negedge clk);
    check("a1_count", 32'(cnt1), 1);
    check("a1_done", 32'(a1.done), 1);
    check("a1_address", 32'(a1.address), 0);
    check("a2_count", 32'(cnt2), 256);
    check("a2_last", 32'(last2), 32'hFF);
    check("a2_address", 32'(a2.address), 32'hFF);
    check("a2_wren", 32'(a2.wren), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
